cordic_rotate: RTL

Rotation-mode CORDIC for the image-processing pipeline: converts a polar pair (magnitude `r`, angle in integer degrees) into Cartesian `x = r·cos(angle)`, `y = r·sin(angle)`. It is the inverse of the vectoring-mode `cordic` angle engine, and it accepts that engine's angle range directly. The block is self-contained: its own iteration counter, arctangent table and control FSM. It serves any stage that projects a point back from an angle and radius.

---
 rtl/cordic_rotate.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cordic_rotate.sv
// Rotation-mode CORDIC: (r, angle in degrees) -> (r*cos, r*sin), one micro-rotation per cycle.
// Build option: define CORDIC_ROT_GAIN_COMP_EN to pre-scale r by 1/K so outputs are unity-gain.
module cordic_rotate #(
  parameter int COORD_DEPTH = 10,
  parameter int ITER        = 12,
  parameter int FRAC        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic        [COORD_DEPTH-1:0] r,
  input  logic signed [9:0]             angle,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic signed [COORD_DEPTH+1:0] x_out,
  output logic signed [COORD_DEPTH+1:0] y_out,
  output logic        [1:0]             state_dbg
);

  localparam int W  = COORD_DEPTH + 2 + FRAC;
  localparam int OW = COORD_DEPTH + 2;
  localparam int ZW = 18;
  localparam logic signed [W-1:0] HALF = W'(1) <<< (FRAC - 1);

  // Handshake: start is sampled only in IDLE; busy covers PREP..OUT plus the done cycle;
  // done is a one-cycle pulse and err is meaningful only while done is high.
  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ROT, S_OUT} state_t;

  state_t                  state;
  logic [COORD_DEPTH-1:0]  r_q;
  logic signed [9:0]       angle_q;
  logic signed [W-1:0]     x_q, y_q;
  logic signed [ZW-1:0]    z_q;
  logic                    err_q;
  logic [4:0]              iter_cnt;

  assign state_dbg = state;

  // arctan(2^-k) in degrees, scaled by 2^8 (table matches FRAC = 8)
  function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] k);
    case (k)
      5'd0:    atan_lut = 18'sd11520;
      5'd1:    atan_lut = 18'sd6801;
      5'd2:    atan_lut = 18'sd3593;
      5'd3:    atan_lut = 18'sd1824;
      5'd4:    atan_lut = 18'sd916;
      5'd5:    atan_lut = 18'sd458;
      5'd6:    atan_lut = 18'sd229;
      5'd7:    atan_lut = 18'sd115;
      5'd8:    atan_lut = 18'sd57;
      5'd9:    atan_lut = 18'sd29;
      5'd10:   atan_lut = 18'sd14;
      5'd11:   atan_lut = 18'sd7;
      5'd12:   atan_lut = 18'sd4;
      5'd13:   atan_lut = 18'sd2;
      5'd14:   atan_lut = 18'sd1;
      default: atan_lut = 18'sd0;
    endcase
  endfunction

  logic signed [10:0]   ang_ext, z_deg;
  logic                 range_bad, neg_x;
  logic signed [W-1:0]  x0_mag, x_init;
  logic signed [ZW-1:0] z_init;
`ifdef CORDIC_ROT_GAIN_COMP_EN
  logic [COORD_DEPTH+15:0] prod;
`endif

  always_comb begin
    ang_ext   = {angle_q[9], angle_q};
    range_bad = (ang_ext < -11'sd180) || (ang_ext > 11'sd359);
    z_deg     = ang_ext;
    neg_x     = 1'b0;
    if (ang_ext >= 11'sd270) begin
      z_deg = ang_ext - 11'sd360;
    end else if (ang_ext > 11'sd90) begin
      z_deg = ang_ext - 11'sd180;
      neg_x = 1'b1;
    end else if (ang_ext < -11'sd90) begin
      z_deg = ang_ext + 11'sd180;
      neg_x = 1'b1;
    end
`ifdef CORDIC_ROT_GAIN_COMP_EN
    prod   = (COORD_DEPTH+16)'(r_q) * (COORD_DEPTH+16)'(39797);
    x0_mag = W'(prod >> (16 - FRAC));
`else
    x0_mag = {{(W-COORD_DEPTH-FRAC){1'b0}}, r_q, {FRAC{1'b0}}};
`endif
    x_init = neg_x ? -x0_mag : x0_mag;
    z_init = $signed({{(ZW-11){z_deg[10]}}, z_deg}) <<< FRAC;
    if (range_bad) begin
      x_init = '0;
      z_init = '0;
    end
  end

  logic                 d_pos;
  logic signed [W-1:0]  x_sh, y_sh, x_nx, y_nx;
  logic signed [ZW-1:0] atan_k, z_nx;

  always_comb begin
    d_pos  = ~z_q[ZW-1];
    x_sh   = x_q >>> iter_cnt;
    y_sh   = y_q >>> iter_cnt;
    atan_k = atan_lut(iter_cnt);
    x_nx   = d_pos ? (x_q - y_sh)   : (x_q + y_sh);
    y_nx   = d_pos ? (y_q + x_sh)   : (y_q - x_sh);
    z_nx   = d_pos ? (z_q - atan_k) : (z_q + atan_k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      iter_cnt <= '0;
      r_q      <= '0;
      angle_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            r_q     <= r;
            angle_q <= angle;
            busy    <= 1'b1;
            state   <= S_PREP;
          end else begin
            busy <= 1'b0;
          end
        end
        S_PREP: begin
          x_q      <= x_init;
          y_q      <= '0;
          z_q      <= z_init;
          err_q    <= range_bad;
          iter_cnt <= '0;
          state    <= S_ROT;
        end
        S_ROT: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          if (iter_cnt == 5'(ITER - 1)) begin
            iter_cnt <= '0;
            state    <= S_OUT;
          end else begin
            iter_cnt <= iter_cnt + 5'd1;
          end
        end
        S_OUT: begin
          // round half up before dropping the guard bits
          x_out <= OW'((x_q + HALF) >>> FRAC);
          y_out <= OW'((y_q + HALF) >>> FRAC);
          done  <= 1'b1;
          err   <= err_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
